kernel_window_fetcher: RTL and testbench

KERNEL_WINDOW_FETCHER -- requirements
Module: kernel_window_fetcher

---
 rtl/kernel_fetch_pkg.sv | 19 +
 rtl/window_addr_gen.sv | 51 +++++
 rtl/kernel_window_fetcher.sv | 147 ++++++++++++++
 tb/tb_kernel_window_fetcher.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_fetch_pkg.sv
// Shared constants and FSM state type for the kernel window fetcher.
package kernel_fetch_pkg;

  localparam int unsigned DefSize  = 3;
  localparam int unsigned DefImgW  = 16;
  localparam int unsigned DefImgH  = 16;
  localparam int unsigned DefAddrW = 16;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCapture,
    StStart,
    StWait,
    StWrite,
    StFdone
  } state_e;

endpackage

// File: rtl/window_addr_gen.sv
// Walks the (i,j) offsets of one SIZE x SIZE window, i fastest, and forms the pixel address.
module window_addr_gen
  import kernel_fetch_pkg::*;
#(
  parameter int unsigned SIZE   = DefSize,
  parameter int unsigned IMG_W  = DefImgW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned CW     = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  output logic [CW-1:0]     i,
  output logic [CW-1:0]     j,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [CW-1:0]     i_q, j_q;
  logic              i_end, j_end;
  logic [ADDR_W-1:0] row, col;

  assign i_end = (i_q == CW'(SIZE - 1));
  assign j_end = (j_q == CW'(SIZE - 1));

  // Counters wrap to (0,0) after the last offset, ready for the next window.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      i_q <= '0;
      j_q <= '0;
    end else if (step) begin
      if (i_end) begin
        i_q <= '0;
        j_q <= j_end ? '0 : j_q + CW'(1);
      end else begin
        i_q <= i_q + CW'(1);
      end
    end
  end

  assign row  = ADDR_W'(y) + ADDR_W'(j_q);
  assign col  = ADDR_W'(x) + ADDR_W'(i_q);
  assign addr = row * ADDR_W'(IMG_W) + col;
  assign i    = i_q;
  assign j    = j_q;
  assign last = i_end && j_end;

endmodule

// File: rtl/kernel_window_fetcher.sv
// Fetches valid-region windows in raster order, hands each to a compute unit and
// writes the returned pixel to the result memory.
module kernel_window_fetcher
  import kernel_fetch_pkg::*;
#(
  parameter int unsigned SIZE   = DefSize,
  parameter int unsigned IMG_W  = DefImgW,
  parameter int unsigned IMG_H  = DefImgH,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame_start,
  input  logic [SIZE-1:0][SIZE-1:0][7:0]   kernel_in,
  output logic                             rd_en,
  output logic [ADDR_W-1:0]                rd_addr,
  input  logic [7:0]                       rd_data,
  output logic [SIZE-1:0][SIZE-1:0][7:0]   input_matrix,
  output logic [SIZE-1:0][SIZE-1:0][7:0]   kernel,
  output logic                             start,
  input  logic                             done,
  input  logic [7:0]                       blurred_pixel,
  output logic                             wr_en,
  output logic [ADDR_W-1:0]                wr_addr,
  output logic [7:0]                       wr_data,
  output logic                             busy,
  output logic                             frame_done
);

  localparam int unsigned OW = IMG_W - SIZE + 1;
  localparam int unsigned OH = IMG_H - SIZE + 1;
  localparam int unsigned CW = $clog2(SIZE);

  state_e state_q, state_d;
  logic [7:0] x_q, x_d, y_q, y_d;

  logic [SIZE-1:0][SIZE-1:0][7:0] matrix_q, kernel_q;
  logic [7:0]                     result_q;
  logic                           cap_valid_q;
  logic [CW-1:0]                  cap_i_q, cap_j_q;

  logic [CW-1:0]     fetch_i, fetch_j;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_last;
  logic              fetching, accept, take_result, row_end, last_window;

  assign fetching    = (state_q == StFetch);
  assign accept      = (state_q == StIdle) && frame_start;
  assign take_result = (state_q == StWait) && done;
  assign row_end     = (x_q == 8'(OW - 1));
  assign last_window = row_end && (y_q == 8'(OH - 1));

  window_addr_gen #(
    .SIZE   (SIZE),
    .IMG_W  (IMG_W),
    .ADDR_W (ADDR_W),
    .CW     (CW)
  ) u_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .step  (fetching),
    .x     (x_q),
    .y     (y_q),
    .i     (fetch_i),
    .j     (fetch_j),
    .addr  (fetch_addr),
    .last  (fetch_last)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d = StFetch;
          x_d     = '0;
          y_d     = '0;
        end
      end
      StFetch:   if (fetch_last) state_d = StCapture;
      StCapture: state_d = StStart;
      StStart:   state_d = StWait;
      StWait:    if (done) state_d = StWrite;
      StWrite: begin
        if (last_window) begin
          state_d = StFdone;
        end else begin
          state_d = StFetch;
          if (row_end) begin
            x_d = '0;
            y_d = y_q + 8'd1;
          end else begin
            x_d = x_q + 8'd1;
          end
        end
      end
      StFdone:   state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Read data lags its strobe by one cycle, so the fetch index is delayed to match.
  always_ff @(posedge clk) begin
    if (rst) begin
      matrix_q    <= '0;
      kernel_q    <= '0;
      result_q    <= '0;
      cap_valid_q <= 1'b0;
      cap_i_q     <= '0;
      cap_j_q     <= '0;
    end else begin
      cap_valid_q <= fetching;
      cap_i_q     <= fetch_i;
      cap_j_q     <= fetch_j;
      if (accept)      kernel_q <= kernel_in;
      if (cap_valid_q) matrix_q[cap_j_q][cap_i_q] <= rd_data;
      if (take_result) result_q <= blurred_pixel;
    end
  end

  assign rd_en        = fetching;
  assign rd_addr      = fetching ? fetch_addr : '0;
  assign start        = (state_q == StStart);
  assign wr_en        = (state_q == StWrite);
  assign wr_addr      = wr_en ? ADDR_W'(y_q) * ADDR_W'(OW) + ADDR_W'(x_q) : '0;
  assign wr_data      = wr_en ? result_q : 8'd0;
  assign busy         = (state_q != StIdle) && (state_q != StFdone);
  assign frame_done   = (state_q == StFdone);
  assign input_matrix = matrix_q;
  assign kernel       = kernel_q;

endmodule

// File: tb/tb_kernel_window_fetcher.sv
// Randomized bench for kernel_window_fetcher: a 5x5 instance and a 3x3 boundary instance,
// each with a pixel memory and a centre-pixel compute unit answering 4 cycles after start.
module tb_kernel_window_fetcher;

  localparam int unsigned SZ = 3;
  localparam int unsigned AW = 16;
  localparam int unsigned WA = 5;
  localparam int unsigned HA = 5;
  localparam int unsigned WB = 3;
  localparam int unsigned HB = 3;
  localparam int unsigned C  = SZ / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A (5x5) ----------------
  logic                         a_frame_start, a_rd_en, a_start, a_done, a_wr_en;
  logic                         a_busy, a_frame_done, a_inj, a_done_m;
  logic [SZ-1:0][SZ-1:0][7:0]   a_kernel_in, a_input_matrix, a_kernel;
  logic [AW-1:0]                a_rd_addr, a_wr_addr;
  logic [7:0]                   a_rd_data, a_res, a_wr_data;
  logic [7:0]                   mem_a [WA*HA];
  int                           a_cnt;

  kernel_window_fetcher #(.SIZE(SZ), .IMG_W(WA), .IMG_H(HA), .ADDR_W(AW)) dut_a (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (a_frame_start),
    .kernel_in     (a_kernel_in),
    .rd_en         (a_rd_en),
    .rd_addr       (a_rd_addr),
    .rd_data       (a_rd_data),
    .input_matrix  (a_input_matrix),
    .kernel        (a_kernel),
    .start         (a_start),
    .done          (a_done),
    .blurred_pixel (a_res),
    .wr_en         (a_wr_en),
    .wr_addr       (a_wr_addr),
    .wr_data       (a_wr_data),
    .busy          (a_busy),
    .frame_done    (a_frame_done)
  );

  always @(posedge clk) a_rd_data <= (a_rd_addr < AW'(WA*HA)) ? mem_a[a_rd_addr] : 8'hEE;

  initial begin a_cnt = 0; a_done_m = 1'b0; a_res = 8'h00; end
  always @(posedge clk) begin
    a_done_m <= 1'b0;
    if (a_start) a_cnt <= 1;
    else if (a_cnt == 3) begin
      a_done_m <= 1'b1;
      a_res    <= a_input_matrix[C][C];
      a_cnt    <= 0;
    end else if (a_cnt != 0) a_cnt <= a_cnt + 1;
  end
  assign a_done = a_done_m | a_inj;

  int a_wa[$], a_wd[$], a_ra[$], a_rc[$], a_sc[$];
  int a_fd = 0;
  always @(negedge clk) begin
    if (a_wr_en) begin a_wa.push_back(int'(a_wr_addr)); a_wd.push_back(int'(a_wr_data)); end
    if (a_rd_en) begin a_ra.push_back(int'(a_rd_addr)); a_rc.push_back(cyc); end
    if (a_start) a_sc.push_back(cyc);
    if (a_frame_done) a_fd++;
  end

  // ---------------- instance B (3x3 boundary) ----------------
  logic                         b_frame_start, b_rd_en, b_start, b_done, b_wr_en;
  logic                         b_busy, b_frame_done;
  logic [SZ-1:0][SZ-1:0][7:0]   b_kernel_in, b_input_matrix, b_kernel;
  logic [AW-1:0]                b_rd_addr, b_wr_addr;
  logic [7:0]                   b_rd_data, b_res, b_wr_data;
  logic [7:0]                   mem_b [WB*HB];
  int                           b_cnt;

  kernel_window_fetcher #(.SIZE(SZ), .IMG_W(WB), .IMG_H(HB), .ADDR_W(AW)) dut_b (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (b_frame_start),
    .kernel_in     (b_kernel_in),
    .rd_en         (b_rd_en),
    .rd_addr       (b_rd_addr),
    .rd_data       (b_rd_data),
    .input_matrix  (b_input_matrix),
    .kernel        (b_kernel),
    .start         (b_start),
    .done          (b_done),
    .blurred_pixel (b_res),
    .wr_en         (b_wr_en),
    .wr_addr       (b_wr_addr),
    .wr_data       (b_wr_data),
    .busy          (b_busy),
    .frame_done    (b_frame_done)
  );

  always @(posedge clk) b_rd_data <= (b_rd_addr < AW'(WB*HB)) ? mem_b[b_rd_addr] : 8'hEE;

  initial begin b_cnt = 0; b_done = 1'b0; b_res = 8'h00; end
  always @(posedge clk) begin
    b_done <= 1'b0;
    if (b_start) b_cnt <= 1;
    else if (b_cnt == 3) begin
      b_done <= 1'b1;
      b_res  <= b_input_matrix[C][C];
      b_cnt  <= 0;
    end else if (b_cnt != 0) b_cnt <= b_cnt + 1;
  end

  int b_wa[$], b_wd[$];
  int b_fd = 0;
  always @(negedge clk) begin
    if (b_wr_en) begin b_wa.push_back(int'(b_wr_addr)); b_wd.push_back(int'(b_wr_data)); end
    if (b_frame_done) b_fd++;
  end

  // ---------------- helpers ----------------
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_a();
    a_wa.delete(); a_wd.delete(); a_ra.delete(); a_rc.delete(); a_sc.delete();
  endtask

  task automatic start_a(input logic [SZ*SZ*8-1:0] k);
    a_kernel_in   = k;
    a_frame_start = 1'b1;
    tick();
    a_frame_start = 1'b0;
  endtask

  task automatic fill_a(input bit ramp);
    for (int p = 0; p < int'(WA*HA); p++) mem_a[p] = ramp ? 8'(p) : 8'($urandom);
  endtask

  task automatic wait_starts_a(input int n, input string tag);
    int k = 0;
    while (a_sc.size() < n && k < 2000) begin tick(); k++; end
    check_eq(tag, a_sc.size() >= n, 1);
  endtask

  // Waits for frame_done, then confirms a one-cycle pulse and busy dropped.
  task automatic wait_fd_a(input string tag);
    int n0 = a_fd;
    int k  = 0;
    while (a_fd == n0 && k < 3000) begin tick(); k++; end
    check_eq({tag, "_fdone"}, a_fd != n0, 1);
    tick();
    check_eq({tag, "_busy_after"}, a_busy, 0);
    tick();
    check_eq({tag, "_fd_pulses"}, a_fd - n0, 1);
  endtask

  // Reference: every valid window in raster order writes its centre pixel to y*OW+x.
  task automatic check_frame_a(input string tag);
    int ow = int'(WA - SZ + 1);
    int oh = int'(HA - SZ + 1);
    check_eq({tag, "_nwr"}, a_wa.size(), ow * oh);
    for (int y = 0; y < oh; y++)
      for (int x = 0; x < ow; x++) begin
        int k = y * ow + x;
        if (k < a_wa.size()) begin
          check_eq($sformatf("%s_addr%0d", tag, k), a_wa[k], k);
          check_eq($sformatf("%s_data%0d", tag, k), a_wd[k],
                   int'(mem_a[(y + int'(C)) * int'(WA) + x + int'(C)]));
        end
      end
  endtask

  task automatic check_idle_a(input string tag);
    check_eq({tag, "_rd_en"}, a_rd_en, 0);
    check_eq({tag, "_rd_addr"}, a_rd_addr, 0);
    check_eq({tag, "_start"}, a_start, 0);
    check_eq({tag, "_wr_en"}, a_wr_en, 0);
    check_eq({tag, "_wr_addr"}, a_wr_addr, 0);
    check_eq({tag, "_wr_data"}, a_wr_data, 0);
    check_eq({tag, "_busy"}, a_busy, 0);
    check_eq({tag, "_fdone"}, a_frame_done, 0);
    check_eq({tag, "_matrix"}, a_input_matrix, 0);
    check_eq({tag, "_kernel"}, a_kernel, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [SZ*SZ*8-1:0] kv;
    int n_wr, n_fd, k;

    rst = 1'b1;
    a_frame_start = 1'b0; a_kernel_in = '0; a_inj = 1'b0;
    b_frame_start = 1'b0; b_kernel_in = '0;
    for (int p = 0; p < int'(WA*HA); p++) mem_a[p] = 8'h00;
    for (int p = 0; p < int'(WB*HB); p++) mem_b[p] = 8'h00;
    repeat (3) tick();
    check_idle_a("rst");
    check_eq("rst_b_busy", b_busy, 0);
    rst = 1'b0;
    tick();

    // Ramp image: first-window addressing, start latency, full frame, kernel hold.
    fill_a(1'b1);
    clear_a();
    kv = (SZ*SZ*8)'({$urandom(), $urandom(), $urandom()});
    start_a(kv);
    check_eq("ramp_busy", a_busy, 1);
    a_kernel_in = ~kv;
    wait_fd_a("ramp");
    check_eq("ramp_nrd", a_ra.size(), 81);
    for (int r = 0; r < int'(SZ*SZ); r++)
      if (r < a_ra.size())
        check_eq($sformatf("ramp_rd%0d", r), a_ra[r], (r / int'(SZ)) * int'(WA) + r % int'(SZ));
    if (a_sc.size() > 0 && a_rc.size() >= int'(SZ*SZ))
      check_eq("start_lat", a_sc[0] - a_rc[SZ*SZ-1], 2);
    else
      check_eq("start_seen", a_sc.size() > 0 && a_rc.size() >= int'(SZ*SZ), 1);
    check_frame_a("ramp");
    check_eq("ramp_kernel", a_kernel, kv);

    // Random images and kernels; kernel_in disturbed mid-frame.
    for (int f = 0; f < 3; f++) begin
      fill_a(1'b0);
      clear_a();
      kv = (SZ*SZ*8)'({$urandom(), $urandom(), $urandom()});
      start_a(kv);
      repeat ($urandom_range(1, 40)) tick();
      a_kernel_in = (SZ*SZ*8)'({$urandom(), $urandom(), $urandom()});
      wait_fd_a($sformatf("rnd%0d", f));
      check_frame_a($sformatf("rnd%0d", f));
      check_eq($sformatf("rnd%0d_kernel", f), a_kernel, kv);
    end

    // Spurious done in FETCH and coinciding with START, frame_start during WAIT.
    fill_a(1'b0);
    clear_a();
    kv = (SZ*SZ*8)'({$urandom(), $urandom(), $urandom()});
    start_a(kv);
    a_inj = 1'b1;
    tick();
    a_inj = 1'b0;
    wait_starts_a(3, "spur_start3");
    a_inj = 1'b1;
    tick();
    a_inj = 1'b0;
    a_frame_start = 1'b1;
    a_kernel_in = ~kv;
    tick();
    a_frame_start = 1'b0;
    wait_fd_a("spur");
    check_frame_a("spur");
    check_eq("spur_kernel", a_kernel, kv);

    // Reset during WAIT of the fourth window; the late done must not write.
    fill_a(1'b0);
    clear_a();
    start_a((SZ*SZ*8)'({$urandom(), $urandom(), $urandom()}));
    wait_starts_a(4, "mid_start4");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_a("midrst");
    n_wr = a_wa.size();
    n_fd = a_fd;
    check_eq("midrst_prior_wr", n_wr, 3);
    repeat (10) tick();
    check_eq("midrst_no_wr", a_wa.size(), n_wr);
    check_eq("midrst_no_fd", a_fd, n_fd);
    check_eq("midrst_idle", a_busy, 0);
    fill_a(1'b0);
    clear_a();
    kv = (SZ*SZ*8)'({$urandom(), $urandom(), $urandom()});
    start_a(kv);
    wait_fd_a("restart");
    check_frame_a("restart");
    check_eq("restart_kernel", a_kernel, kv);

    // Boundary instance: image equals window, single output pixel.
    for (int p = 0; p < int'(WB*HB); p++) mem_b[p] = 8'($urandom);
    kv = (SZ*SZ*8)'({$urandom(), $urandom(), $urandom()});
    b_kernel_in   = kv;
    b_frame_start = 1'b1;
    tick();
    b_frame_start = 1'b0;
    b_kernel_in   = ~kv;
    k = 0;
    while (b_fd == 0 && k < 500) begin tick(); k++; end
    check_eq("bnd_fdone", b_fd, 1);
    tick();
    check_eq("bnd_busy_after", b_busy, 0);
    check_eq("bnd_nwr", b_wa.size(), 1);
    if (b_wa.size() > 0) begin
      check_eq("bnd_addr", b_wa[0], 0);
      check_eq("bnd_data", b_wd[0], int'(mem_b[C * WB + C]));
    end
    check_eq("bnd_kernel", b_kernel, kv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
